// File: rtl/bmat_pkg.sv
// Shared definitions for the 8x8 GF(2) bit-matrix units.
// Layout: element (row r, col c) is bit r*8+c, so row r is byte r.
package bmat_pkg;

  localparam int          BMAT_N        = 8;
  localparam logic [63:0] BMAT_IDENTITY = 64'h8040201008040201;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } bmat_state_t;

  // GF(2) matrix product a*b: row r of the result is the XOR of the rows j
  // of b selected by the set bits of row r of a.
  function automatic logic [63:0] bmat_mul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] c;
    c = '0;
    for (int r = 0; r < BMAT_N; r++)
      for (int j = 0; j < BMAT_N; j++)
        if (a[r*BMAT_N + j]) c[r*BMAT_N +: BMAT_N] ^= b[j*BMAT_N +: BMAT_N];
    return c;
  endfunction

endpackage

// File: rtl/bmat_inv_step.sv
// One Gauss-Jordan elimination step on pivot column k, applied to the
// working matrix a and the companion matrix b. Purely combinational.
module bmat_inv_step
  import bmat_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  k,
  output logic [63:0] a_nxt,
  output logic [63:0] b_nxt,
  output logic        no_pivot
);

  logic [7:0][7:0] ra, rb, sa, sb, oa, ob;
  logic [2:0]      p;

  assign ra    = a;
  assign rb    = b;
  assign a_nxt = oa;
  assign b_nxt = ob;

  // Pick the lowest pivot row >= k, swap it into row k, then clear column k
  // in every other row using the post-swap row k.
  always_comb begin
    no_pivot = 1'b1;
    p        = '0;
    // scan downward so the lowest qualifying row wins
    for (int r = BMAT_N - 1; r >= 0; r--) begin
      if (r >= int'(k) && ra[r][k]) begin
        p        = 3'(r);
        no_pivot = 1'b0;
      end
    end

    sa = ra;
    sb = rb;
    if (!no_pivot) begin
      sa[k] = ra[p];
      sa[p] = ra[k];
      sb[k] = rb[p];
      sb[p] = rb[k];
    end

    oa = sa;
    ob = sb;
    if (!no_pivot) begin
      for (int i = 0; i < BMAT_N; i++) begin
        if (3'(i) != k && sa[i][k]) begin
          oa[i] = sa[i] ^ sa[k];
          ob[i] = sb[i] ^ sb[k];
        end
      end
    end
  end

endmodule

// File: rtl/bmat_inv.sv
// Iterative GF(2) inverter for 8x8 bit matrices with valid/ready handshakes.
// STEPS_PER_CYCLE pivot columns are eliminated per clock (1, 2, 4 or 8).
// Optional BMATINV_CHECK_EN adds a CHECK state that multiplies the original
// matrix by the computed inverse and flags check_err on a mismatch.
module bmat_inv
  import bmat_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] rs1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] rd,
  output logic        singular,
  output logic        check_err
);

  localparam logic [2:0] K_LAST = 3'(BMAT_N - STEPS_PER_CYCLE);
  localparam logic [2:0] K_INC  = 3'(STEPS_PER_CYCLE);

  bmat_state_t state, state_nxt;
  logic [63:0] a_w, b_w;
  logic        sing;
  logic [2:0]  k;

  logic [63:0]                ca [STEPS_PER_CYCLE+1];
  logic [63:0]                cb [STEPS_PER_CYCLE+1];
  logic [STEPS_PER_CYCLE-1:0] np;
  logic                       last_step;
  logic                       sing_fin;

  assign ca[0] = a_w;
  assign cb[0] = b_w;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    bmat_inv_step u_step (
      .a        (ca[g]),
      .b        (cb[g]),
      .k        (k + 3'(g)),
      .a_nxt    (ca[g+1]),
      .b_nxt    (cb[g+1]),
      .no_pivot (np[g])
    );
  end

  assign last_step = (k == K_LAST);
  assign sing_fin  = sing | (|np);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; latency is data independent.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_STEP;
      S_STEP: if (last_step) begin
`ifdef BMATINV_CHECK_EN
        state_nxt = S_CHECK;
`else
        state_nxt = S_DONE;
`endif
      end
      S_CHECK: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Working matrices, pivot index, sticky singular flag and result capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_w      <= '0;
      b_w      <= '0;
      sing     <= 1'b0;
      k        <= '0;
      rd       <= '0;
      singular <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_w  <= rs1;
          b_w  <= BMAT_IDENTITY;
          sing <= 1'b0;
          k    <= '0;
        end
        S_STEP: begin
          a_w  <= ca[STEPS_PER_CYCLE];
          b_w  <= cb[STEPS_PER_CYCLE];
          sing <= sing_fin;
          k    <= k + K_INC;
`ifndef BMATINV_CHECK_EN
          if (last_step) begin
            rd       <= sing_fin ? 64'h0 : cb[STEPS_PER_CYCLE];
            singular <= sing_fin;
          end
`endif
        end
`ifdef BMATINV_CHECK_EN
        S_CHECK: begin
          rd       <= sing ? 64'h0 : b_w;
          singular <= sing;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef BMATINV_CHECK_EN
  logic [63:0] a_orig;

  // Keep the original matrix and verify A*B == I once elimination finishes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_orig    <= '0;
      check_err <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        a_orig    <= rs1;
        check_err <= 1'b0;
      end
      if (state == S_CHECK)
        check_err <= !sing && (bmat_mul(a_orig, b_w) != BMAT_IDENTITY);
    end
  end
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_bmat_inv.sv
// Scoreboard bench for bmat_inv: a driver pushes expectations, a monitor
// pops and checks them whenever the DUT presents a result.
module tb_bmat_inv;
  import bmat_pkg::*;

`ifdef BMATINV_CHECK_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] rs1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] rd;
  logic        singular;
  logic        check_err;

  bmat_inv dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .singular  (singular),
    .check_err (check_err)
  );

  typedef struct {
    logic [63:0] a;
    bit          sing;
    bit          has_rd;
    logic [63:0] rd;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          hold    = 1'b0;
  bit          seen    = 1'b0;
  logic [63:0] held_rd;
  logic        held_s;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference rank test: the row space has 256 members iff all 8 rows
  // are linearly independent.
  function automatic bit full_rank(logic [63:0] a);
    bit [255:0] span, nsp;
    int cnt;
    span = '0;
    span[0] = 1'b1;
    for (int r = 0; r < 8; r++) begin
      nsp = span;
      for (int x = 0; x < 256; x++)
        if (span[x]) nsp[x ^ int'(a[r*8 +: 8])] = 1'b1;
      span = nsp;
    end
    cnt = 0;
    for (int x = 0; x < 256; x++) cnt += int'(span[x]);
    return cnt == 256;
  endfunction

  task automatic send(logic [63:0] a, bit has, logic [63:0] r);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    rs1      = a;
    e.a      = a;
    e.sing   = !full_rank(a);
    e.has_rd = has;
    e.rd     = r;
    e.acc    = cyc + 1;
    q.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || !in_ready) && w < 400) begin
      @(negedge clock);
      w++;
    end
    if (q.size() != 0 || !in_ready) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: check each result on its first valid cycle, then hold stability.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (!resetn) seen = 1'b0;
    else if (out_valid) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      if (!seen) begin
        if (q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'(LAT));
          chk("singular", 64'(singular), 64'(e.sing));
          if (e.sing) chk("rd_singular_zero", rd, 64'h0);
          else        chk("a_times_rd", bmat_mul(e.a, rd), BMAT_IDENTITY);
          if (e.has_rd) chk("rd_value", rd, e.rd);
          chk("check_err", 64'(check_err), 64'd0);
        end
        held_rd = rd;
        held_s  = singular;
        seen    = 1'b1;
      end else begin
        chk("rd_stable", rd, held_rd);
        chk("singular_stable", 64'(singular), 64'(held_s));
      end
      if (out_ready) seen = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int          w;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rd", rd, 64'h0);
    chk("rst_singular", 64'(singular), 64'd0);
    chk("rst_check_err", 64'(check_err), 64'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed matrices with known inverses.
    send(64'h8040201008040201, 1'b1, 64'h8040201008040201);
    send(64'hFF7F3F1F0F070301, 1'b1, 64'hC06030180C060301);
    send(64'h0102040810204080, 1'b1, 64'h0102040810204080);
    send(64'h0000000000000000, 1'b1, 64'h0);
    send(64'h0000000000000101, 1'b1, 64'h0);
    drain();

    // Backpressure: result must hold while extra requests are ignored.
    hold = 1'b1;
    send(64'hFF7F3F1F0F070301, 1'b1, 64'hC06030180C060301);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clock);
      in_valid = 1'b1;
      rs1      = 64'h8040201008040201;
    end
    @(negedge clock);
    in_valid = 1'b0;
    hold     = 1'b0;
    drain();
    repeat (20) @(negedge clock);

    // Asynchronous reset in the middle of elimination.
    send(64'h0102040810204080, 1'b1, 64'h0102040810204080);
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_rd", rd, 64'h0);
    q.delete();
    @(negedge clock);
    resetn = 1'b1;
    send(64'h8040201008040201, 1'b1, 64'h8040201008040201);
    drain();

    // Random matrices, with some forced duplicate rows and sparse inputs.
    for (int i = 0; i < 2000; i++) begin
      a = {$urandom, $urandom};
      if (i % 5 == 0) a[$urandom_range(7)*8 +: 8] = a[$urandom_range(7)*8 +: 8];
      if (i % 7 == 0) a = a & {$urandom, $urandom};
      send(a, 1'b0, 64'h0);
    end
    drain();
    repeat (20) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
